// File: rtl/uart_pkg.sv
// Shared UART types and elaboration helpers for the transmitter (and the future receiver).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Producer-side valid/ready handshake for uart_tx_param; master = producer, slave = transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 parity_en;
  logic                 parity_odd;

  modport master (output tx_valid, tx_data, parity_en, parity_odd, input tx_ready);
  modport slave  (input tx_valid, tx_data, parity_en, parity_odd, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Baud clock-enable: counts 0..CLKS_PER_BIT-1, tick on the last count, held at 0 by clear.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST);
endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, tx_ready=1, waiting for tx_valid
// START  | start bit (low) for one bit time
// DATA   | shifting out data bits, LSB first
// PARITY | parity bit (only with UART_TX_PARITY_EN)
// STOP   | STOP_BITS high bit times, tx_done on the final tick
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_param_if.slave bus,
  output logic           tx,
  output logic           busy,
  output logic           tx_done
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_param: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS out of range");
  end

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, busy_q, done_q, done_d;
  logic                 tick;

`ifdef UART_TX_PARITY_EN
  logic par_act_q, par_act_d, par_bit_q, par_bit_d;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = bus.parity_en ^ bus.parity_odd;
`endif

  // Counter is held clear while idle so the first bit after accept is a full bit time.
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state_q == IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_act_d = par_act_q;
    par_bit_d = par_bit_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.tx_valid && ready_q) begin
          state_d   = START;
          shift_d   = bus.tx_data;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_act_d = bus.parity_en;
          par_bit_d = (^bus.tx_data) ^ bus.parity_odd;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = STOP;
            tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (par_act_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          tx_d = 1'b1;
          if (bit_cnt_q == LAST_STOP) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      ready_q   <= (state_d == IDLE);
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_act_q <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      par_act_q <= par_act_d;
      par_bit_q <= par_bit_d;
    end
  end
`endif

  assign bus.tx_ready = ready_q;
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign tx_done      = done_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param at 10 clks/bit; an 8N1 and a 7-data/2-stop instance.
// Expected parity frames depend on UART_TX_PARITY_EN.
module tb_uart_tx_param;
  localparam int CPB = 10;

  logic clk;
  logic rst_n;
  logic tx8, busy8, done8;
  logic tx7, busy7, done7;
  int   n_checks;
  int   n_fail;

  uart_tx_param_if #(.DATA_BITS(8)) bus8 ();
  uart_tx_param_if #(.DATA_BITS(7)) bus7 ();

  uart_tx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8), .tx(tx8), .busy(busy8), .tx_done(done8)
  );

  uart_tx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .STOP_BITS(2)) dut7 (
    .clk(clk), .rst_n(rst_n), .bus(bus7), .tx(tx7), .busy(busy7), .tx_done(done7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller sets tx_data/tx_valid at a sample point; the next edge accepts and tx falls
  // (clk 0). line[i] is the expected level of bit i; tx_done is expected at clk nbits*CPB.
  task automatic check_frame(input bit sel7, input logic [15:0] line, input int nbits,
                             input bit hold, input logic [8:0] next_data, input string name);
    int   len;
    bit   bad;
    logic o_tx, o_busy, o_done, o_ready, exp_tx;
    logic f_tx, f_busy, f_done, f_ready, f_exp;
    len = nbits * CPB;
    bad = 1'b0;
    {f_tx, f_busy, f_done, f_ready, f_exp} = '0;
    for (int c = 0; c <= len; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        if (sel7) begin
          bus7.tx_data = next_data[6:0];
          if (!hold) bus7.tx_valid = 1'b0;
        end else begin
          bus8.tx_data = next_data[7:0];
          if (!hold) bus8.tx_valid = 1'b0;
        end
      end
      o_tx    = sel7 ? tx7 : tx8;
      o_busy  = sel7 ? busy7 : busy8;
      o_done  = sel7 ? done7 : done8;
      o_ready = sel7 ? bus7.tx_ready : bus8.tx_ready;
      if (c < len) begin
        exp_tx = line[c / CPB];
        if (!bad && (o_tx !== exp_tx || o_busy !== 1'b1 || o_done !== 1'b0 || o_ready !== 1'b0)) begin
          bad = 1'b1;
          {f_tx, f_busy, f_done, f_ready, f_exp} = {o_tx, o_busy, o_done, o_ready, exp_tx};
        end
        if (c % CPB == CPB - 1) begin
          n_checks++;
          if (bad) begin
            n_fail++;
            $display("FAIL %s bit %0d: got tx=%b busy=%b done=%b ready=%b, expected tx=%b busy=1 done=0 ready=0",
                     name, c / CPB, f_tx, f_busy, f_done, f_ready, f_exp);
          end
          bad = 1'b0;
        end
      end else begin
        n_checks++;
        if (o_done !== 1'b1 || o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s end at clk %0d: got done=%b tx=%b ready=%b busy=%b, expected done=1 tx=1 ready=1 busy=0",
                   name, len, o_done, o_tx, o_ready, o_busy);
        end
      end
    end
  endtask

  task automatic check_after_done(input bit sel7, input string name);
    logic o_tx, o_done;
    @(posedge clk); #1;
    o_tx   = sel7 ? tx7 : tx8;
    o_done = sel7 ? done7 : done8;
    n_checks++;
    if (o_done !== 1'b0 || o_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL %s post-done: got done=%b tx=%b, expected done=0 tx=1", name, o_done, o_tx);
    end
  endtask

  task automatic test_reset();
    bit b_tx, b_ready, b_busy, b_done;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({tx8, bus8.tx_ready, busy8, done8, tx7, bus7.tx_ready, busy7, done7} !== 8'b1100_1100) begin
      n_fail++;
      $display("FAIL reset_state: got %b, expected 11001100",
               {tx8, bus8.tx_ready, busy8, done8, tx7, bus7.tx_ready, busy7, done7});
    end
    rst_n = 1'b1;
    {b_tx, b_ready, b_busy, b_done} = '0;
    repeat (50) begin
      @(posedge clk); #1;
      if (tx8 !== 1'b1 || tx7 !== 1'b1) b_tx = 1'b1;
      if (bus8.tx_ready !== 1'b1 || bus7.tx_ready !== 1'b1) b_ready = 1'b1;
      if (busy8 !== 1'b0 || busy7 !== 1'b0) b_busy = 1'b1;
      if (done8 !== 1'b0 || done7 !== 1'b0) b_done = 1'b1;
    end
    n_checks++;
    if (b_tx) begin n_fail++; $display("FAIL idle_tx: got tx=0 during idle, expected 1"); end
    n_checks++;
    if (b_ready) begin n_fail++; $display("FAIL idle_ready: got tx_ready=0 during idle, expected 1"); end
    n_checks++;
    if (b_busy) begin n_fail++; $display("FAIL idle_busy: got busy=1 during idle, expected 0"); end
    n_checks++;
    if (b_done) begin n_fail++; $display("FAIL idle_done: got tx_done=1 during idle, expected 0"); end
  endtask

  task automatic test_basic();
    bus8.tx_data  = 8'hA5;
    bus8.tx_valid = 1'b1;
    check_frame(1'b0, 16'({1'b1, 8'hA5, 1'b0}), 10, 1'b0, 9'h000, "a5_8n1");
    check_after_done(1'b0, "a5_8n1");
  endtask

  task automatic test_parity();
    bus8.parity_en  = 1'b1;
    bus8.parity_odd = 1'b0;
    bus8.tx_data    = 8'hA5;
    bus8.tx_valid   = 1'b1;
`ifdef UART_TX_PARITY_EN
    check_frame(1'b0, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 1'b0, 9'h000, "a5_even");
`else
    check_frame(1'b0, 16'({1'b1, 8'hA5, 1'b0}), 10, 1'b0, 9'h000, "a5_even_nopar");
`endif
    check_after_done(1'b0, "a5_even");
    bus8.parity_odd = 1'b1;
    bus8.tx_data    = 8'hA5;
    bus8.tx_valid   = 1'b1;
`ifdef UART_TX_PARITY_EN
    check_frame(1'b0, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, 1'b0, 9'h000, "a5_odd");
`else
    check_frame(1'b0, 16'({1'b1, 8'hA5, 1'b0}), 10, 1'b0, 9'h000, "a5_odd_nopar");
`endif
    check_after_done(1'b0, "a5_odd");
    bus8.parity_en  = 1'b0;
    bus8.parity_odd = 1'b0;
  endtask

  task automatic test_7d2s();
    bus7.tx_data  = 7'h7F;
    bus7.tx_valid = 1'b1;
    check_frame(1'b1, 16'({2'b11, 7'h7F, 1'b0}), 10, 1'b0, 9'h000, "7f_7n2");
    check_after_done(1'b1, "7f_7n2");
  endtask

  task automatic test_back_to_back();
    bit bad;
    bus8.tx_data  = 8'h55;
    bus8.tx_valid = 1'b1;
    check_frame(1'b0, 16'({1'b1, 8'h55, 1'b0}), 10, 1'b1, 9'h00F, "b2b_55");
    check_frame(1'b0, 16'({1'b1, 8'h0F, 1'b0}), 10, 1'b0, 9'h0F0, "b2b_0f");
    bad = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL b2b_no_extra: got activity after second frame, expected idle"); end
  endtask

  task automatic test_reset_mid_frame();
    bit bad;
    bus8.tx_data  = 8'hA5;
    bus8.tx_valid = 1'b1;
    for (int c = 0; c <= 45; c++) begin
      @(posedge clk); #1;
      if (c == 0) bus8.tx_valid = 1'b0;
    end
    n_checks++;
    if (tx8 !== 1'b0 || busy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_bit3: got tx=%b busy=%b, expected tx=0 busy=1", tx8, busy8);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 || bus8.tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got tx=%b busy=%b done=%b ready=%b, expected 1 0 0 1",
               tx8, busy8, done8, bus8.tx_ready);
    end
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) bad = 1'b1;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL reset_abandon: got line activity or tx_done after reset, expected idle"); end
    bus8.tx_data  = 8'h3C;
    bus8.tx_valid = 1'b1;
    check_frame(1'b0, 16'({1'b1, 8'h3C, 1'b0}), 10, 1'b0, 9'h000, "3c_after_reset");
    check_after_done(1'b0, "3c_after_reset");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus8.tx_valid = 1'b0; bus8.tx_data = '0; bus8.parity_en = 1'b0; bus8.parity_odd = 1'b0;
    bus7.tx_valid = 1'b0; bus7.tx_data = '0; bus7.parity_en = 1'b0; bus7.parity_odd = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_7d2s();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised next-generation UART transmitter: serialises one frame per accepted word.
- Frame format: start bit, DATA_BITS data bits LSB-first, optional parity bit, STOP_BITS stop bits.
- Bit timing comes from a clock-enable baud tick in the system clock domain. No derived clock.
- Sits between a producer (CPU register block or FIFO, valid/ready handshake) and the pad-level serial line.

Parameters:
- CLK_FREQ, 1000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bits/s. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, must be >= 2; elaboration error otherwise).
- DATA_BITS, 8, data bits per frame, legal range 5..9.
- STOP_BITS, 1, stop bits per frame, legal 1 or 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- tx_valid  input  1  producer has a word.
- tx_data  input  DATA_BITS  word to send.
- tx_ready  output  1  block can accept a word this cycle.
- parity_en  input  1  add parity bit; sampled at accept (ignored without macro).
- parity_odd  input  1  1 = odd parity, 0 = even; sampled at accept (ignored without macro).
- tx  output  1  serial line, idles high.
- busy  output  1  frame in progress.
- tx_done  output  1  one-clk pulse at end of last stop bit.

Behaviour:
- Reset (async assert): state IDLE, tx=1, tx_ready=1, busy=0, tx_done=0, baud counter=0, bit counter=0. Reset mid-frame abandons the frame immediately: tx goes high, no tx_done.
- Handshake: accept when tx_valid && tx_ready at a rising edge. Latch tx_data, parity_en and parity_odd into a shift register and config flops. tx_ready=1 only in IDLE. tx_data may change after accept.
- States:
  - IDLE -> START on accept.
  - START -> DATA after 1 bit time.
  - DATA -> PARITY after DATA_BITS bit times when parity is active, otherwise DATA -> STOP.
  - PARITY -> STOP after 1 bit time.
  - STOP -> IDLE after STOP_BITS bit times.
- Timing:
  - Baud counter counts 0..CLKS_PER_BIT-1 and is cleared on accept. tick = (counter == CLKS_PER_BIT-1).
  - Every bit, including each stop bit, holds tx for exactly CLKS_PER_BIT clocks.
  - tx goes low on the cycle after accept.
- Data bits are sent LSB first by shifting right. The bit counter advances only on tick.
- Parity: even = XOR of the DATA_BITS data bits; odd = its inverse. Computed from the latched word.
- End of frame:
  - On the tick ending the last stop bit, the state moves to IDLE and tx_done=1 for exactly one cycle. tx stays 1. tx_ready rises in that same cycle.
  - If tx_valid is still high, the next word is accepted on the following edge. Minimum inter-frame gap is 1 clk of idle-high line.
- busy = (state != IDLE). tx, tx_ready, busy and tx_done are all registered outputs.
- Frame length in clks = (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT, where P = 1 if parity is active.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state and parity logic are compiled in, and parity_en/parity_odd are honoured.
- Undefined: PARITY state and logic are removed, parity_en/parity_odd are ignored (ports remain), and frames never carry a parity bit.

Decomposition:
- Package uart_pkg holds:
  - uart_tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - The CLKS_PER_BIT computation function.
  - Legal-range constants for DATA_BITS and STOP_BITS.
- Sub-module uart_baud_gen: parametrised tick generator with clear input and tick output. It is reused by the future receiver.

Test Plan (CLK_FREQ=1000000, BAUD_RATE=100000 -> 10 clks/bit unless stated):
- Reset, then idle 50 clks -> tx=1, tx_ready=1, busy=0, tx_done never pulses.
- Send 0xA5, no parity, 1 stop -> tx low 10 clks, then data bits 1,0,1,0,0,1,0,1 (10 clks each), then high 10 clks. tx_done pulses once 100 clks after tx falls.
- With macro: 0xA5, parity_en=1, even -> parity bit 0; odd -> parity bit 1; frame is 110 clks. Without macro: same stimulus gives a 100-clk frame.
- DATA_BITS=7, STOP_BITS=2, send 0x7F -> 7 ones, then 20 clks high, then tx_done.
- tx_valid held high with 0x55 then 0x0F -> second start bit falls exactly 1 clk after the first frame's tx_done. No word is lost or duplicated.
- Assert rst_n low mid-DATA bit 3 -> tx=1 immediately (asynchronous), busy=0, no tx_done. After release, a fresh 0x3C frame is sent correctly.
